// File: rtl/game_tick_ctrl_if.sv
// Signal bundle between the game tick controller (slave) and the game logic that drives it (master).
interface game_tick_ctrl_if;
  logic        start;
  logic        pause;
  logic [2:0]  speed_lvl;
  logic        tick_ack;
  logic        vga_ce;
  logic        rand_ce;
  logic        game_tick;
  logic        running;
  logic        paused;
  logic        overrun;
  logic [15:0] tick_cnt;

  modport master (
    output start, pause, speed_lvl, tick_ack,
    input  vga_ce, rand_ce, game_tick, running, paused, overrun, tick_cnt
  );

  modport slave (
    input  start, pause, speed_lvl, tick_ack,
    output vga_ce, rand_ce, game_tick, running, paused, overrun, tick_cnt
  );
endinterface

// File: rtl/game_tick_ctrl.sv
// Central game timing: free-running VGA/random clock enables plus a speed-programmable
// game tick under a start/pause FSM, delivered with a request/acknowledge handshake.
module game_tick_ctrl #(
  parameter int CNT_W     = 32,
  parameter int VGA_DIV   = 4,
  parameter int RAND_DIV  = 32768,
  parameter int GAME_BASE = 50000000,
  parameter int GAME_STEP = 5000000,
  parameter int GAME_MIN  = 5000000
) (
  input  logic            clk,
  input  logic            rst,
  game_tick_ctrl_if.slave bus
);

  localparam int VGA_W  = (VGA_DIV  > 1) ? $clog2(VGA_DIV)  : 1;
  localparam int RAND_W = (RAND_DIV > 1) ? $clog2(RAND_DIV) : 1;
  localparam int PW     = CNT_W + 4;

  localparam logic [VGA_W-1:0]  VGA_LAST  = VGA_W'(VGA_DIV - 1);
  localparam logic [RAND_W-1:0] RAND_LAST = RAND_W'(RAND_DIV - 1);
  localparam logic [PW-1:0]     HEADROOM  = PW'(GAME_BASE - GAME_MIN);
  localparam logic [PW-1:0]     STEP_EXT  = PW'(GAME_STEP);
  localparam logic [CNT_W-1:0]  BASE_P    = CNT_W'(GAME_BASE);
  localparam logic [CNT_W-1:0]  MIN_P     = CNT_W'(GAME_MIN);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t              state;
  logic [VGA_W-1:0]    vga_cnt;
  logic [RAND_W-1:0]   rand_cnt;
  logic [CNT_W-1:0]    game_cnt;
  logic [CNT_W-1:0]    period_q;
  logic [PW-1:0]       step_prod;
  logic [CNT_W-1:0]    period_calc;
  logic                tick_ev;
  logic                running_q;
  logic                paused_q;
  logic                game_tick_q;
  logic                overrun_q;
  logic [15:0]         tick_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_cnt  <= '0;
      rand_cnt <= '0;
    end else begin
      vga_cnt  <= (vga_cnt == VGA_LAST)   ? '0 : vga_cnt + VGA_W'(1);
      rand_cnt <= (rand_cnt == RAND_LAST) ? '0 : rand_cnt + RAND_W'(1);
    end
  end

  assign bus.vga_ce  = (vga_cnt == VGA_LAST);
  assign bus.rand_ce = (rand_cnt == RAND_LAST);

  // Product is computed wide so the clamp comparison can never underflow the period.
  assign step_prod   = PW'(bus.speed_lvl) * STEP_EXT;
  assign period_calc = (step_prod > HEADROOM) ? MIN_P : BASE_P - step_prod[CNT_W-1:0];

  assign tick_ev = (state == RUN) && (game_cnt == period_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      game_cnt  <= '0;
      period_q  <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          game_cnt <= '0;
          if (bus.start) begin
            state     <= RUN;
            period_q  <= period_calc;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          // The count of the cycle in which pause is sampled is still taken.
          if (tick_ev) begin
            game_cnt <= '0;
            period_q <= period_calc;
          end else begin
            game_cnt <= game_cnt + CNT_W'(1);
          end
          if (bus.pause) begin
            state     <= PAUSE;
            running_q <= 1'b0;
            paused_q  <= 1'b1;
          end
        end
        PAUSE: begin
          if (!bus.pause) begin
            state     <= RUN;
            running_q <= 1'b1;
            paused_q  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          game_cnt  <= '0;
          running_q <= 1'b0;
          paused_q  <= 1'b0;
        end
      endcase
    end
  end

  // A new tick overrides a same-cycle ack; an unacked tick is flagged, never queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      game_tick_q <= 1'b0;
      overrun_q   <= 1'b0;
      tick_cnt_q  <= '0;
    end else if (tick_ev) begin
      game_tick_q <= 1'b1;
      tick_cnt_q  <= tick_cnt_q + 16'd1;
      if (game_tick_q && !bus.tick_ack) begin
        overrun_q <= 1'b1;
      end
    end else if (game_tick_q && bus.tick_ack) begin
      game_tick_q <= 1'b0;
    end
  end

  assign bus.game_tick = game_tick_q;
  assign bus.running   = running_q;
  assign bus.paused    = paused_q;
  assign bus.overrun   = overrun_q;
  assign bus.tick_cnt  = tick_cnt_q;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Directed self-checking bench for game_tick_ctrl with small periods (VGA 4, RAND 8, game 20/4/4).
module tb_game_tick_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic auto_ack = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  game_tick_ctrl_if bus ();

  game_tick_ctrl #(
    .CNT_W    (32),
    .VGA_DIV  (4),
    .RAND_DIV (8),
    .GAME_BASE(20),
    .GAME_STEP(4),
    .GAME_MIN (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance n edges; outputs are then sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (auto_ack) bus.tick_ack = bus.game_tick;
    end
  endtask

  task automatic apply_stimulus(input logic st, input logic pa, input logic [2:0] lvl, input logic ack);
    bus.start     = st;
    bus.pause     = pa;
    bus.speed_lvl = lvl;
    bus.tick_ack  = ack;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [2:0] lvl);
    auto_ack = 1'b0;
    apply_stimulus(1'b0, 1'b0, lvl, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  initial begin
    // Reset state and free-running enables with no start
    do_reset(3'd0);
    check_output("rst_running", bus.running, 0);
    check_output("rst_paused", bus.paused, 0);
    check_output("rst_overrun", bus.overrun, 0);
    for (int c = 0; c < 100; c++) begin
      check_output("idle_vga_ce", bus.vga_ce, (c % 4) == 3);
      check_output("idle_rand_ce", bus.rand_ce, (c % 8) == 7);
      check_output("idle_game_tick", bus.game_tick, 0);
      check_output("idle_running", bus.running, 0);
      check_output("idle_tick_cnt", bus.tick_cnt, 0);
      step(1);
    end

    // Level 0 with ack tied to game_tick: period 20
    do_reset(3'd0);
    auto_ack = 1'b1;
    start_game();
    check_output("l0_running", bus.running, 1);
    check_output("l0_paused", bus.paused, 0);
    for (int k = 1; k <= 100; k++) begin
      step(1);
      check_output("l0_game_tick", bus.game_tick, (k % 20) == 0);
      check_output("l0_tick_cnt", bus.tick_cnt, k / 20);
    end
    check_output("l0_overrun", bus.overrun, 0);

    // Level 3 (period 8), switch to 7 mid-period (clamped 4), then back to 0
    do_reset(3'd3);
    auto_ack = 1'b1;
    start_game();
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 4) bus.speed_lvl = 3'd7;
      check_output("l3_game_tick", bus.game_tick, (k == 8) || (k > 8 && ((k - 8) % 4) == 0));
    end
    check_output("l3_tick_cnt", bus.tick_cnt, 4);
    bus.speed_lvl = 3'd0;
    for (int k = 21; k <= 44; k++) begin
      step(1);
      check_output("l0_after_l7_tick", bus.game_tick, (k == 24) || (k == 44));
    end
    check_output("l0_after_l7_cnt", bus.tick_cnt, 6);

    // Level 4 (period exactly 4): ack coinciding with a tick event, then overrun
    do_reset(3'd4);
    start_game();
    step(4);
    check_output("l4_tick1", bus.game_tick, 1);
    check_output("l4_cnt1", bus.tick_cnt, 1);
    step(3);
    check_output("l4_hold", bus.game_tick, 1);
    bus.tick_ack = 1'b1;
    step(1);
    check_output("l4_ack_tick_same", bus.game_tick, 1);
    check_output("l4_ack_tick_ovr", bus.overrun, 0);
    check_output("l4_cnt2", bus.tick_cnt, 2);
    bus.tick_ack = 1'b0;
    step(4);
    check_output("l4_ovr", bus.overrun, 1);
    check_output("l4_cnt3", bus.tick_cnt, 3);

    // Level 0 with no ack: overrun on second tick event
    do_reset(3'd0);
    start_game();
    for (int k = 1; k <= 45; k++) begin
      step(1);
      check_output("noack_game_tick", bus.game_tick, k >= 20);
      check_output("noack_overrun", bus.overrun, k >= 40);
      check_output("noack_tick_cnt", bus.tick_cnt, k / 20);
    end
    bus.tick_ack = 1'b1;
    step(1);
    bus.tick_ack = 1'b0;
    check_output("late_ack_clear", bus.game_tick, 0);
    check_output("late_ack_ovr_sticky", bus.overrun, 1);
    step(14);
    check_output("noack_tick3", bus.game_tick, 1);
    check_output("noack_cnt3", bus.tick_cnt, 3);

    // Pause with the count frozen at 12 for 30 cycles; start ignored while paused
    do_reset(3'd0);
    auto_ack = 1'b1;
    start_game();
    step(11);
    bus.pause = 1'b1;
    step(1);
    check_output("pause_paused", bus.paused, 1);
    check_output("pause_running", bus.running, 0);
    bus.start = 1'b1;
    for (int i = 1; i <= 29; i++) begin
      step(1);
      check_output("pause_hold", bus.paused, 1);
      check_output("pause_no_tick", bus.game_tick, 0);
    end
    bus.pause = 1'b0;
    bus.start = 1'b0;
    step(1);
    check_output("resume_running", bus.running, 1);
    check_output("resume_paused", bus.paused, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check_output("resume_tick", bus.game_tick, k == 8);
    end
    check_output("resume_cnt", bus.tick_cnt, 1);

    // Reset while ticking, overrun and paused; reset beats a same-edge start
    do_reset(3'd0);
    start_game();
    step(40);
    check_output("pre_rst_tick", bus.game_tick, 1);
    check_output("pre_rst_ovr", bus.overrun, 1);
    bus.pause = 1'b1;
    step(1);
    check_output("pre_rst_paused", bus.paused, 1);
    rst = 1'b1;
    bus.start = 1'b1;
    step(1);
    rst = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    check_output("post_rst_running", bus.running, 0);
    check_output("post_rst_paused", bus.paused, 0);
    check_output("post_rst_tick", bus.game_tick, 0);
    check_output("post_rst_ovr", bus.overrun, 0);
    check_output("post_rst_cnt", bus.tick_cnt, 0);
    check_output("post_rst_vga", bus.vga_ce, 0);
    check_output("post_rst_rand", bus.rand_ce, 0);
    for (int c = 1; c <= 8; c++) begin
      step(1);
      check_output("post_rst_vga_seq", bus.vga_ce, (c % 4) == 3);
      check_output("post_rst_rand_seq", bus.rand_ce, (c % 8) == 7);
      check_output("post_rst_idle", bus.running, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
